// File: rtl/lut_config_loader.sv
// lut_config_loader: streams one LUT truth table in over a CHUNK-wide
// valid/ready port into a shadow register. A complete table is copied to
// the active configuration in a single cycle, so the select mux never sees
// a partly written table.
// Optional feature: define LUT_CONFIG_PARITY_EN to enable per-beat parity
// checking. A load with any bad beat still takes all beats, then sets the
// sticky error flag instead of committing.
module lut_config_loader #(
   parameter int INPUTS = 4,
   parameter int WIDTH  = 1 << INPUTS,
   parameter int CHUNK  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CHUNK-1:0] in_data,
   input  logic             in_parity,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [WIDTH-1:0] config_values,
   output logic             config_valid
);

   localparam int BEATS = WIDTH / CHUNK;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] cfg_q, cfg_d;
   logic             cfg_valid_q, cfg_valid_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic             err_seen_q, err_seen_d;
   logic             beat_bad;

`ifdef LUT_CONFIG_PARITY_EN
   assign beat_bad = (in_parity != ^in_data);
`else
   logic unused_parity;
   assign unused_parity = in_parity;
   assign beat_bad      = 1'b0;
`endif

   // The handshake is decoded from the state register alone, so in_ready
   // never depends combinationally on in_valid.
   assign in_ready      = (state_q == LOAD);
   assign busy          = (state_q != IDLE);
   assign done          = done_q;
   assign error         = error_q;
   assign config_values = cfg_q;
   assign config_valid  = cfg_valid_q;

   // Next-state, beat assembly and commit logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shadow_d    = shadow_q;
      cfg_d       = cfg_q;
      cfg_valid_d = cfg_valid_q;
      done_d      = 1'b0;
      error_d     = error_q;
      err_seen_d  = err_seen_q;
      case (state_q)
         IDLE: begin
            // abort beats a coincident start
            if (start && !abort) begin
               cnt_d      = '0;
               err_seen_d = 1'b0;
               error_d    = 1'b0;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            if (abort) begin
               // A beat arriving with abort is consumed and dropped.
               state_d = IDLE;
            end else if (in_valid) begin
               for (int b = 0; b < BEATS; b++)
                  if (cnt_q == CW'(b)) shadow_d[b*CHUNK +: CHUNK] = in_data;
               if (beat_bad) err_seen_d = 1'b1;
               if (cnt_q == CW'(BEATS-1)) begin
                  cnt_d = '0;
                  if (err_seen_q || beat_bad) begin
                     error_d = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = COMMIT;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         COMMIT: begin
            cfg_d       = shadow_q;
            cfg_valid_d = 1'b1;
            done_d      = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shadow_q    <= '0;
         cfg_q       <= '0;
         cfg_valid_q <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_seen_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shadow_q    <= shadow_d;
         cfg_q       <= cfg_d;
         cfg_valid_q <= cfg_valid_d;
         done_q      <= done_d;
         error_q     <= error_d;
         err_seen_q  <= err_seen_d;
      end
   end

endmodule
